// File: rtl/tdm_demux_1xn_if.sv
// Lane and output bundle for the 1:N TDM demultiplexer.
// The source drives the shared lane and the demux drives the channel outputs.
interface tdm_demux_1xn_if #(
    parameter int N_CH = 4,
    parameter int W    = 8
);
    logic [W-1:0]      din;
    logic              din_valid;
    logic              frame_sync;
    logic [N_CH*W-1:0] dout;
    logic [N_CH-1:0]   dout_valid;
    logic              frame_done;
    logic              locked;
    logic              sync_err;

    modport master (
        output din, din_valid, frame_sync,
        input  dout, dout_valid, frame_done, locked, sync_err
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output dout, dout_valid, frame_done, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux_1xn.sv
// 1:N time-division demultiplexer: locks to frame sync and steers each lane
// beat into its per-channel holding register, flagging framing violations.
module tdm_demux_1xn #(
    parameter int N_CH = 4,
    parameter int W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    tdm_demux_1xn_if.slave bus
);
    localparam int              SW        = $clog2(N_CH);
    localparam logic [SW-1:0]   SLOT_ZERO = {SW{1'b0}};
    localparam logic [SW-1:0]   SLOT_ONE  = SW'(1);
    localparam logic [SW-1:0]   LAST_SLOT = SW'(N_CH - 1);

    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_r;
    logic [SW-1:0]     slot_r;
    logic [N_CH*W-1:0] dout_r;
    logic [N_CH-1:0]   dout_valid_r;
    logic              frame_done_r;
    logic              locked_r;
    logic              sync_err_r;

    logic              accept_s;
    logic [N_CH-1:0]   tgt_sel_s;

    function automatic logic [N_CH-1:0] slot_onehot(input logic [SW-1:0] s);
        logic [N_CH-1:0] oh;
        oh = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (SW'(i) == s) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    // Decode which channel this beat targets and whether it is captured at all.
    // A sync beat always lands in ch0, even when it arrives early.
    always_comb begin
        tgt_sel_s = {N_CH{1'b0}};
        accept_s  = 1'b0;
        if (bus.frame_sync) begin
            tgt_sel_s = slot_onehot(SLOT_ZERO);
        end else begin
            tgt_sel_s = slot_onehot(slot_r);
        end
        case (state_r)
            ST_HUNT:   accept_s = bus.din_valid & bus.frame_sync;
            ST_LOCKED: accept_s = bus.din_valid & (bus.frame_sync | (slot_r != SLOT_ZERO));
            default:   accept_s = 1'b0;
        endcase
    end

    // Framing FSM, slot counter, holding registers and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_HUNT;
            slot_r       <= SLOT_ZERO;
            dout_r       <= {(N_CH*W){1'b0}};
            dout_valid_r <= {N_CH{1'b0}};
            frame_done_r <= 1'b0;
            locked_r     <= 1'b0;
            sync_err_r   <= 1'b0;
        end else begin
            dout_valid_r <= accept_s ? tgt_sel_s : {N_CH{1'b0}};
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                if (accept_s && tgt_sel_s[i]) begin
                    dout_r[i*W +: W] <= bus.din;
                end
            end
            if (bus.din_valid) begin
                case (state_r)
                    ST_HUNT: begin
                        if (bus.frame_sync) begin
                            state_r  <= ST_LOCKED;
                            locked_r <= 1'b1;
                            slot_r   <= SLOT_ONE;
                        end
                    end
                    ST_LOCKED: begin
                        if (bus.frame_sync) begin
                            // Early sync abandons the partial frame and restarts at slot 1.
                            sync_err_r <= (slot_r != SLOT_ZERO);
                            slot_r     <= SLOT_ONE;
                        end else if (slot_r == SLOT_ZERO) begin
                            sync_err_r <= 1'b1;
                            state_r    <= ST_HUNT;
                            locked_r   <= 1'b0;
                        end else begin
                            frame_done_r <= (slot_r == LAST_SLOT);
                            slot_r       <= (slot_r == LAST_SLOT) ? SLOT_ZERO : slot_r + SLOT_ONE;
                        end
                    end
                    default: begin
                        state_r  <= ST_HUNT;
                        locked_r <= 1'b0;
                        slot_r   <= SLOT_ZERO;
                    end
                endcase
            end
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.frame_done = frame_done_r;
    assign bus.locked     = locked_r;
    assign bus.sync_err   = sync_err_r;
endmodule

// File: tb/tb_tdm_demux_1xn.sv
// Scoreboard bench for tdm_demux_1xn: a behavioural framing model pushes the
// expected next-cycle outputs per driven cycle; they are popped after the edge.
module tb_tdm_demux_1xn;
    localparam int N_CH = 4;
    localparam int W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tdm_demux_1xn_if #(.N_CH(N_CH), .W(W)) bus ();

    tdm_demux_1xn #(.N_CH(N_CH), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CH*W-1:0] dout;
        logic [N_CH-1:0]   dv;
        logic              fd;
        logic              lk;
        logic              se;
    } exp_t;

    exp_t       sb_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         fd_seen      = 0;
    int         se_seen      = 0;
    string      phase        = "init";

    logic [W-1:0] m_ch [N_CH];
    int           m_slot   = 0;
    logic         m_locked = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", phase, tag, obs, expv);
        end
    endtask

    // Behavioural model of one clock edge; pushes the outputs expected after it.
    task automatic model_push(input logic r, input logic v, input logic fs, input logic [W-1:0] d);
        exp_t e;
        e = '0;
        if (r) begin
            for (int i = 0; i < N_CH; i++) m_ch[i] = '0;
            m_slot   = 0;
            m_locked = 1'b0;
        end else if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_ch[0]  = d;
                    e.dv     = 4'b0001;
                    m_slot   = 1;
                    m_locked = 1'b1;
                end
            end else if (fs) begin
                e.se    = (m_slot != 0);
                m_ch[0] = d;
                e.dv    = 4'b0001;
                m_slot  = 1;
            end else if (m_slot == 0) begin
                e.se     = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_ch[m_slot] = d;
                e.dv         = 4'b0001 << m_slot;
                e.fd         = (m_slot == N_CH - 1);
                m_slot       = (m_slot + 1) % N_CH;
            end
        end
        for (int i = 0; i < N_CH; i++) e.dout[i*W +: W] = m_ch[i];
        e.lk = m_locked;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic r, input logic v, input logic fs, input logic [W-1:0] d);
        exp_t e;
        rst            = r;
        bus.din_valid  = v;
        bus.frame_sync = fs;
        bus.din        = d;
        model_push(r, v, fs, d);
        @(posedge clk);
        #1;
        if (bus.frame_done === 1'b1) fd_seen++;
        if (bus.sync_err === 1'b1) se_seen++;
        e = sb_q.pop_front();
        check_eq("dout", 64'(bus.dout), 64'(e.dout));
        check_eq("dout_valid", 64'(bus.dout_valid), 64'(e.dv));
        check_eq("frame_done", 64'(bus.frame_done), 64'(e.fd));
        check_eq("locked", 64'(bus.locked), 64'(e.lk));
        check_eq("sync_err", 64'(bus.sync_err), 64'(e.se));
    endtask

    task automatic beat(input logic fs, input logic [W-1:0] d);
        step(1'b0, 1'b1, fs, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, W'($urandom));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int fd0;
        int se0;
        bus.din        = '0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        for (int i = 0; i < N_CH; i++) m_ch[i] = '0;

        phase = "reset";
        do_reset(1);
        step(1'b1, 1'b1, 1'b1, 8'h5A);
        check_eq("rst_dout", 64'(bus.dout), 64'h0);
        check_eq("rst_locked", 64'(bus.locked), 64'h0);

        phase = "frame";
        fd0 = fd_seen;
        beat(1'b1, 8'h11);
        check_eq("locked_rise", 64'(bus.locked), 64'h1);
        beat(1'b0, 8'h22);
        beat(1'b0, 8'h33);
        beat(1'b0, 8'h44);
        check_eq("dout_final", 64'(bus.dout), 64'h44332211);
        check_eq("fd_count", 64'(fd_seen - fd0), 64'd1);

        phase = "hunt";
        do_reset(1);
        fd0 = fd_seen;
        beat(1'b0, 8'hAA);
        check_eq("aa_dropped", 64'(bus.dout_valid), 64'h0);
        beat(1'b0, 8'hBB);
        beat(1'b1, 8'h11);
        beat(1'b0, 8'h22);
        beat(1'b0, 8'h33);
        beat(1'b0, 8'h44);
        check_eq("dout_final", 64'(bus.dout), 64'h44332211);
        check_eq("fd_count", 64'(fd_seen - fd0), 64'd1);

        phase = "early_sync";
        fd0 = fd_seen;
        se0 = se_seen;
        beat(1'b1, 8'h55);
        beat(1'b0, 8'h66);
        beat(1'b1, 8'h77);
        check_eq("se_on_77", 64'(bus.sync_err), 64'h1);
        beat(1'b0, 8'h88);
        beat(1'b0, 8'h99);
        beat(1'b0, 8'hA0);
        check_eq("fd_on_a0", 64'(bus.frame_done), 64'h1);
        check_eq("dout_final", 64'(bus.dout), 64'hA0998877);
        check_eq("fd_count", 64'(fd_seen - fd0), 64'd1);
        check_eq("se_count", 64'(se_seen - se0), 64'd1);

        phase = "missing_sync";
        beat(1'b0, 8'hC3);
        check_eq("se", 64'(bus.sync_err), 64'h1);
        check_eq("no_dv", 64'(bus.dout_valid), 64'h0);
        check_eq("locked_fall", 64'(bus.locked), 64'h0);
        check_eq("ch0_hold", 64'(bus.dout), 64'hA0998877);

        phase = "gaps";
        fd0 = fd_seen;
        beat(1'b1, 8'h01);
        idle(3);
        beat(1'b0, 8'h02);
        idle(1);
        beat(1'b0, 8'h03);
        beat(1'b0, 8'h04);
        check_eq("dout_final", 64'(bus.dout), 64'h04030201);
        check_eq("fd_count", 64'(fd_seen - fd0), 64'd1);

        phase = "mid_reset";
        fd0 = fd_seen;
        beat(1'b1, 8'h11);
        beat(1'b0, 8'h22);
        do_reset(1);
        check_eq("dout_after_rst", 64'(bus.dout), 64'h0);
        beat(1'b0, 8'h33);
        beat(1'b0, 8'h44);
        check_eq("dout_final", 64'(bus.dout), 64'h0);
        check_eq("locked", 64'(bus.locked), 64'h0);
        check_eq("fd_count", 64'(fd_seen - fd0), 64'd0);

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            logic rv;
            logic rfs;
            logic rr;
            rv  = ($urandom_range(0, 3) != 0);
            rfs = ($urandom_range(0, 4) == 0);
            rr  = ($urandom_range(0, 60) == 0);
            step(rr, rv, rfs, W'($urandom));
        end

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
